// File: rtl/imm_decode_stage.sv
// imm_decode_stage
// ----------------
// Registered immediate-decode stage between the IFU and the EXU. Each accepted
// 32-bit RV instruction is classified by immediate format. The XLEN-wide
// immediate is built and registered together with the PC. A two-entry buffer
// (main register plus skid register) keeps full throughput under backpressure.
// Unsupported encodings are flagged and counted in a saturating counter.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   flush                 synchronous kill of every buffered entry
//   in_valid/in_ready     upstream handshake (in_ready is registered)
//   in_inst, in_pc        instruction word and its PC
//   out_valid/out_ready   downstream handshake
//   out_pc, out_imm       PC and extended immediate of the head entry
//   out_type              0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
//   out_illegal           head entry has an unsupported encoding
//   illegal_cnt           saturating count of accepted illegal instructions
module imm_decode_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_type_e;

    localparam bit IS64 = (XLEN == 64);

    imm_type_e       dec_type;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;

    logic            main_valid;
    logic [XLEN-1:0] main_pc;
    logic [XLEN-1:0] main_imm;
    logic [2:0]      main_type;
    logic            main_illegal;

    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_type;
    logic            skid_illegal;

    logic            accept;
    logic            deliver;

    // Format classification from the opcode. The RV64-only W opcodes are
    // rejected as illegal when the stage is built for RV32.
    always_comb begin
        dec_type    = IMM_NONE;
        dec_illegal = 1'b0;
        if (in_inst[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (in_inst[6:0])
                7'b0010011, 7'b0000011, 7'b1100111: dec_type = IMM_I;
                7'b0011011: begin
                    if (IS64) dec_type = IMM_I;
                    else      dec_illegal = 1'b1;
                end
                7'b0100011:             dec_type = IMM_S;
                7'b1100011:             dec_type = IMM_B;
                7'b0110111, 7'b0010111: dec_type = IMM_U;
                7'b1101111:             dec_type = IMM_J;
                7'b1110011: begin
                    if (in_inst[14]) dec_type = IMM_Z;
                end
                7'b0110011, 7'b0001111: dec_type = IMM_NONE;
                7'b0111011: begin
                    if (!IS64) dec_illegal = 1'b1;
                end
                default:                dec_illegal = 1'b1;
            endcase
        end
    end

    // Immediate assembly. Sign extension comes from sizing a signed field
    // up to XLEN. The CSR zimm field is zero-extended.
    always_comb begin
        dec_imm = '0;
        case (dec_type)
            IMM_I: dec_imm = XLEN'($signed(in_inst[31:20]));
            IMM_S: dec_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            IMM_B: dec_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                             in_inst[11:8], 1'b0}));
            IMM_U: dec_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            IMM_J: dec_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                             in_inst[30:21], 1'b0}));
            IMM_Z: dec_imm = XLEN'(in_inst[19:15]);
            default: dec_imm = '0;
        endcase
    end

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready & ~flush;
    assign deliver  = main_valid & out_ready;

    // Buffer control. The pair {main_valid, skid_valid} is the EMPTY/BUSY/FULL
    // occupancy. The skid register is only filled while the main register
    // stalls, so the output stays FIFO-ordered. Flush drops both entries and
    // wins over a same-cycle deliver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid   <= 1'b0;
            main_pc      <= '0;
            main_imm     <= '0;
            main_type    <= '0;
            main_illegal <= 1'b0;
            skid_valid   <= 1'b0;
            skid_pc      <= '0;
            skid_imm     <= '0;
            skid_type    <= '0;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid) begin
            if (accept) begin
                main_valid   <= 1'b1;
                main_pc      <= in_pc;
                main_imm     <= dec_imm;
                main_type    <= dec_type;
                main_illegal <= dec_illegal;
            end
        end else if (skid_valid) begin
            if (deliver) begin
                main_pc      <= skid_pc;
                main_imm     <= skid_imm;
                main_type    <= skid_type;
                main_illegal <= skid_illegal;
                skid_valid   <= 1'b0;
            end
        end else begin
            if (accept && deliver) begin
                main_pc      <= in_pc;
                main_imm     <= dec_imm;
                main_type    <= dec_type;
                main_illegal <= dec_illegal;
            end else if (accept) begin
                skid_valid   <= 1'b1;
                skid_pc      <= in_pc;
                skid_imm     <= dec_imm;
                skid_type    <= dec_type;
                skid_illegal <= dec_illegal;
            end else if (deliver) begin
                main_valid <= 1'b0;
            end
        end
    end

    // Illegal-instruction counter. It saturates at all-ones and survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (accept && dec_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    assign out_valid   = main_valid;
    assign out_pc      = main_pc;
    assign out_imm     = main_imm;
    assign out_type    = main_type;
    assign out_illegal = main_illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage
// -------------------
// Bench for imm_decode_stage. Instance "a" is RV64 with a 2-bit counter, and
// instance "b" is RV32 with the default 8-bit counter. Directed scenarios check
// against hand-derived constants. The random scenario checks against a
// queue-based model of the stage contents.
module tb_imm_decode_stage;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
    logic [31:0] a_in_inst;
    logic [63:0] a_in_pc, a_out_pc, a_out_imm;
    logic [2:0]  a_out_type;
    logic [1:0]  a_illegal_cnt;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
    logic [31:0] b_in_inst;
    logic [31:0] b_in_pc, b_out_pc, b_out_imm;
    logic [2:0]  b_out_type;
    logic [7:0]  b_illegal_cnt;

    entry_t q[$];
    int     cnt_a_model;

    imm_decode_stage #(.XLEN(64), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inst(a_in_inst), .in_pc(a_in_pc),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
        .out_imm(a_out_imm), .out_type(a_out_type), .out_illegal(a_out_illegal),
        .illegal_cnt(a_illegal_cnt)
    );

    imm_decode_stage #(.XLEN(32), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst), .in_pc(b_in_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
        .out_imm(b_out_imm), .out_type(b_out_type), .out_illegal(b_out_illegal),
        .illegal_cnt(b_illegal_cnt)
    );

    // Reference decode: offsets are computed as signed values scaled by their
    // implied alignment (x2 for branches/jumps, x4096 for upper immediates).
    function automatic entry_t ref_decode(input logic [31:0] inst, input logic [63:0] pc,
                                          input bit is64);
        entry_t e;
        logic signed [63:0] v;
        logic [6:0] op;
        op    = inst[6:0];
        v     = 64'sd0;
        e.pc  = pc;
        e.typ = 3'd0;
        e.ill = 1'b0;
        if (inst[1:0] != 2'b11) begin
            e.ill = 1'b1;
        end else begin
            case (op)
                7'h13, 7'h03, 7'h67: begin e.typ = 3'd1; v = $signed(inst[31:20]); end
                7'h1B: begin
                    if (is64) begin e.typ = 3'd1; v = $signed(inst[31:20]); end
                    else e.ill = 1'b1;
                end
                7'h23: begin e.typ = 3'd2; v = $signed({inst[31:25], inst[11:7]}); end
                7'h63: begin
                    e.typ = 3'd3;
                    v = $signed({inst[31], inst[7], inst[30:25], inst[11:8]});
                    v = v * 2;
                end
                7'h37, 7'h17: begin
                    e.typ = 3'd4;
                    v = $signed(inst[31:12]);
                    v = v * 4096;
                end
                7'h6F: begin
                    e.typ = 3'd5;
                    v = $signed({inst[31], inst[19:12], inst[20], inst[30:21]});
                    v = v * 2;
                end
                7'h73: begin
                    if (inst[14]) begin e.typ = 3'd6; v = {59'd0, inst[19:15]}; end
                end
                7'h33, 7'h0F: e.typ = 3'd0;
                7'h3B: if (!is64) e.ill = 1'b1;
                default: e.ill = 1'b1;
            endcase
        end
        e.imm = v;
        return e;
    endfunction

    function automatic logic [6:0] pick_op(input int k);
        case (k)
            0: return 7'h13;  1: return 7'h03;  2: return 7'h67;  3: return 7'h1B;
            4: return 7'h23;  5: return 7'h63;  6: return 7'h37;  7: return 7'h17;
            8: return 7'h6F;  9: return 7'h73; 10: return 7'h33; 11: return 7'h0F;
            default: return 7'h3B;
        endcase
    endfunction

    // One clock of stimulus on instance a, with the queue model advanced to
    // match. Returns #1 after the rising edge so outputs can be sampled.
    task automatic drive_a(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                           input logic rdy, input logic fl);
        bit acc, del;
        entry_t e;
        a_in_valid  = v;
        a_in_inst   = inst;
        a_in_pc     = pc;
        a_out_ready = rdy;
        a_flush     = fl;
        acc = v && (q.size() < 2) && !fl;
        del = (q.size() > 0) && rdy;
        e   = ref_decode(inst, pc, 1'b1);
        if (fl) begin
            q.delete();
        end else begin
            if (del) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        if (acc && e.ill && cnt_a_model < 3) cnt_a_model++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                           input logic rdy);
        b_in_valid  = v;
        b_in_inst   = inst;
        b_in_pc     = pc;
        b_out_ready = rdy;
        b_flush     = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_handshake got valid=%b ready=%b want valid=0 ready=1",
                     a_out_valid, a_in_ready);
        end
        checks++;
        if (a_out_pc !== 64'd0 || a_out_imm !== 64'd0 || a_out_type !== 3'd0 ||
            a_out_illegal !== 1'b0 || a_illegal_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_data got pc=%h imm=%h type=%0d ill=%b cnt=%0d want all 0",
                     a_out_pc, a_out_imm, a_out_type, a_out_illegal, a_illegal_cnt);
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_illegal_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_b got valid=%b ready=%b cnt=%0d want 0/1/0",
                     b_out_valid, b_in_ready, b_illegal_cnt);
        end
    endtask

    task automatic test_addi();
        drive_a(1'b1, 32'hFFF00093, 64'h1000, 1'b1, 1'b0);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_type !== 3'd1 || a_out_illegal !== 1'b0 ||
            a_out_imm !== 64'hFFFF_FFFF_FFFF_FFFF || a_out_pc !== 64'h1000) begin
            errors++;
            $display("[TB] FAIL addi got v=%b type=%0d ill=%b imm=%h pc=%h want 1/1/0/all-ones/1000",
                     a_out_valid, a_out_type, a_out_illegal, a_out_imm, a_out_pc);
        end
    endtask

    task automatic test_formats();
        logic [31:0] insts[4];
        logic [63:0] imms[4];
        logic [2:0]  types[4];
        insts[0] = 32'hFE112E23; imms[0] = 64'hFFFF_FFFF_FFFF_FFFC; types[0] = 3'd2;
        insts[1] = 32'hFE000EE3; imms[1] = 64'hFFFF_FFFF_FFFF_FFFC; types[1] = 3'd3;
        insts[2] = 32'h800002B7; imms[2] = 64'hFFFF_FFFF_8000_0000; types[2] = 3'd4;
        insts[3] = 32'h0040006F; imms[3] = 64'h0000_0000_0000_0004; types[3] = 3'd5;
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, insts[i], 64'h2000 + 64'(i * 4), 1'b1, 1'b0);
            checks++;
            if (a_out_valid !== 1'b1 || a_out_type !== types[i] || a_out_imm !== imms[i] ||
                a_out_pc !== 64'h2000 + 64'(i * 4)) begin
                errors++;
                $display("[TB] FAIL format_%0d got v=%b type=%0d imm=%h pc=%h want type=%0d imm=%h",
                         i, a_out_valid, a_out_type, a_out_imm, a_out_pc, types[i], imms[i]);
            end
        end
        drive_a(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL format_drain got valid=%b want 0", a_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive_a(1'b1, 32'h00100093, 64'h100, 1'b0, 1'b0);
        drive_a(1'b1, 32'h00200093, 64'h104, 1'b0, 1'b0);
        checks++;
        if (a_in_ready !== 1'b0 || a_out_pc !== 64'h100) begin
            errors++;
            $display("[TB] FAIL bp_full got ready=%b pc=%h want ready=0 pc=100", a_in_ready, a_out_pc);
        end
        drive_a(1'b1, 32'h00300093, 64'h108, 1'b0, 1'b0);
        checks++;
        if (a_in_ready !== 1'b0 || a_out_pc !== 64'h100 || a_out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_hold got ready=%b v=%b pc=%h want 0/1/100",
                     a_in_ready, a_out_valid, a_out_pc);
        end
        drive_a(1'b1, 32'h00300093, 64'h108, 1'b1, 1'b0);
        checks++;
        if (a_in_ready !== 1'b1 || a_out_pc !== 64'h104 || a_out_imm !== 64'd2) begin
            errors++;
            $display("[TB] FAIL bp_second got ready=%b pc=%h imm=%h want 1/104/2",
                     a_in_ready, a_out_pc, a_out_imm);
        end
        drive_a(1'b1, 32'h00300093, 64'h108, 1'b1, 1'b0);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_pc !== 64'h108 || a_out_imm !== 64'd3) begin
            errors++;
            $display("[TB] FAIL bp_third got v=%b pc=%h imm=%h want 1/108/3",
                     a_out_valid, a_out_pc, a_out_imm);
        end
        drive_a(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_drain got valid=%b want 0", a_out_valid);
        end
    endtask

    task automatic test_flush();
        drive_a(1'b1, 32'h00100093, 64'h180, 1'b0, 1'b0);
        drive_a(1'b1, 32'h00200093, 64'h184, 1'b0, 1'b0);
        drive_a(1'b1, 32'h00700093, 64'h200, 1'b1, 1'b1);
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_clear got valid=%b ready=%b want 0/1", a_out_valid, a_in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
            checks++;
            if (a_out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL flush_dropped_%0d got valid=%b pc=%h want valid=0",
                         i, a_out_valid, a_out_pc);
            end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 5; i++) begin
            drive_a(1'b1, 32'h00000000, 64'h300 + 64'(i * 4), 1'b1, 1'b0);
            checks++;
            if (a_out_valid !== 1'b1 || a_out_illegal !== 1'b1 || a_out_type !== 3'd0 ||
                a_out_imm !== 64'd0 || a_illegal_cnt !== ((i < 2) ? 2'(i + 1) : 2'd3)) begin
                errors++;
                $display("[TB] FAIL saturate_%0d got v=%b ill=%b type=%0d imm=%h cnt=%0d want cnt=%0d",
                         i, a_out_valid, a_out_illegal, a_out_type, a_out_imm, a_illegal_cnt,
                         (i < 2) ? i + 1 : 3);
            end
        end
        drive_a(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] inst;
        logic        v, rdy, fl;
        int          bad;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            inst = $urandom;
            if ($urandom_range(0, 3) != 0) inst[6:0] = pick_op($urandom_range(0, 12));
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            drive_a(v, inst, {32'h0, $urandom}, rdy, fl);
            checks++;
            if (a_out_valid !== (q.size() > 0) || a_in_ready !== (q.size() < 2) ||
                a_illegal_cnt !== 2'(cnt_a_model)) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("[TB] FAIL rand_ctrl cycle %0d got v=%b rdy=%b cnt=%0d want v=%b rdy=%b cnt=%0d",
                             c, a_out_valid, a_in_ready, a_illegal_cnt, q.size() > 0,
                             q.size() < 2, cnt_a_model);
            end
            if (q.size() > 0) begin
                checks++;
                if (a_out_pc !== q[0].pc || a_out_imm !== q[0].imm ||
                    a_out_type !== q[0].typ || a_out_illegal !== q[0].ill) begin
                    errors++;
                    bad++;
                    if (bad < 10)
                        $display("[TB] FAIL rand_data cycle %0d got pc=%h imm=%h type=%0d ill=%b want pc=%h imm=%h type=%0d ill=%b",
                                 c, a_out_pc, a_out_imm, a_out_type, a_out_illegal,
                                 q[0].pc, q[0].imm, q[0].typ, q[0].ill);
                end
            end
        end
    endtask

    task automatic test_xlen32_reset();
        drive_b(1'b1, 32'h0000501B, 32'h400, 1'b1);
        checks++;
        if (b_out_valid !== 1'b1 || b_out_illegal !== 1'b1 || b_out_type !== 3'd0 ||
            b_out_imm !== 32'd0) begin
            errors++;
            $display("[TB] FAIL rv32_w_op got v=%b ill=%b type=%0d imm=%h want 1/1/0/0",
                     b_out_valid, b_out_illegal, b_out_type, b_out_imm);
        end
        drive_b(1'b1, 32'h800002B7, 32'h404, 1'b1);
        checks++;
        if (b_out_type !== 3'd4 || b_out_imm !== 32'h8000_0000 || b_out_illegal !== 1'b0 ||
            b_illegal_cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL rv32_lui got type=%0d imm=%h ill=%b cnt=%0d want 4/80000000/0/1",
                     b_out_type, b_out_imm, b_out_illegal, b_illegal_cnt);
        end
        b_in_valid = 1'b1;
        b_in_inst  = 32'h00000000;
        a_in_valid = 1'b1;
        a_in_inst  = 32'h00000000;
        a_out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (b_out_valid !== 1'b0 || b_illegal_cnt !== 8'd0 || a_out_valid !== 1'b0 ||
            a_illegal_cnt !== 2'd0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset got b_v=%b b_cnt=%0d a_v=%b a_cnt=%0d a_rdy=%b want 0/0/0/0/1",
                     b_out_valid, b_illegal_cnt, a_out_valid, a_illegal_cnt, a_in_ready);
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_inst = '0; a_in_pc = '0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_inst = '0; b_in_pc = '0; b_out_ready = 1'b0;
        cnt_a_model = 0;
        #12;
        test_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] addi");
        test_addi();
        $display("[TB] formats");
        test_formats();
        $display("[TB] back_to_back");
        test_back_to_back();
        $display("[TB] flush");
        test_flush();
        $display("[TB] saturate");
        test_saturate();
        $display("[TB] random");
        test_random();
        $display("[TB] xlen32 and mid-stream reset");
        test_xlen32_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
